axi_sram_slave: RTL

AXI3-style 32-bit slave (responder) backed by an on-chip byte-writable SRAM. It sits on the far side of the cache arbiter's outer AXI port and replaces the external memory controller in simulation and small FPGA builds. It serves one read burst and one write burst at a time, and the two run concurrently and independently. IDs are echoed back so the arbiter can steer R beats to the I-cache or D-cache.

---
 rtl/axi_pkg.sv | 37 +++
 rtl/axi_sram_array.sv | 35 +++
 rtl/axi_sram_slave.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI response/burst types, FSM states and burst address helper
package axi_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'b00,
        W_DATA = 2'b01,
        W_RESP = 2'b10
    } wr_state_t;

    // WRAP and the reserved encoding walk forward exactly like INCR.
    function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                              input logic [2:0]  size,
                                              input logic [1:0]  burst);
        logic [31:0] step;
        step = (size > 3'd2) ? 32'd4 : (32'd1 << size);
        return (burst == BURST_FIXED) ? addr : addr + step;
    endfunction

endpackage

// File: rtl/axi_sram_array.sv
// rtl/axi_sram_array.sv - 2^ADDR_W x 32 SRAM, registered read port, byte-enabled write port
module axi_sram_array #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb
);

    logic [31:0] mem [0:(1<<ADDR_W)-1];

    // Read only on request so the output holds while the master stalls;
    // a same-cycle write to the same word is seen by the next read.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) begin
                    mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/axi_sram_slave.sv
// rtl/axi_sram_slave.sv - AXI3-style SRAM responder with independent read and write burst engines
module axi_sram_slave
    import axi_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic [1:0]  arlock,
    input  logic [3:0]  arcache,
    input  logic [2:0]  arprot,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic [1:0]  awlock,
    input  logic [3:0]  awcache,
    input  logic [2:0]  awprot,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    logic unused_ok;
    assign unused_ok = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid};

    rd_state_t   rd_state;
    logic [3:0]  rd_id;
    logic [31:0] rd_addr;
    logic [7:0]  rd_len;
    logic [7:0]  rd_cnt;
    logic [2:0]  rd_size;
    logic [1:0]  rd_burst;
    logic [31:0] rd_addr_nxt;
    logic        ar_fire;
    logic        r_fire;
    logic [31:0] mem_rdata;

    assign ar_fire     = arvalid && arready;
    assign r_fire      = rvalid && rready;
    assign rd_addr_nxt = next_addr(rd_addr, rd_size, rd_burst);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state <= R_IDLE;
            rd_id    <= 4'd0;
            rd_addr  <= 32'd0;
            rd_len   <= 8'd0;
            rd_cnt   <= 8'd0;
            rd_size  <= 3'd0;
            rd_burst <= 2'd0;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (arvalid) begin
                        rd_id    <= arid;
                        rd_addr  <= araddr;
                        rd_len   <= arlen;
                        rd_size  <= arsize;
                        rd_burst <= arburst;
                        rd_cnt   <= 8'd0;
                        rd_state <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rready) begin
                        rd_addr <= rd_addr_nxt;
                        rd_cnt  <= rd_cnt + 8'd1;
                        if (rd_cnt == rd_len) begin
                            rd_state <= R_IDLE;
                        end
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    assign arready = (rd_state == R_IDLE) && !rst;
    assign rvalid  = (rd_state == R_DATA);
    assign rid     = rd_id;
    assign rlast   = rvalid && (rd_cnt == rd_len);
    assign rresp   = (rvalid && rd_size > 3'd2) ? RESP_SLVERR : RESP_OKAY;
    assign rdata   = rvalid ? mem_rdata : 32'd0;

    wr_state_t   wr_state;
    logic [3:0]  wr_id;
    logic [31:0] wr_addr;
    logic [7:0]  wr_len;
    logic [7:0]  wr_cnt;
    logic [2:0]  wr_size;
    logic [1:0]  wr_burst;
    logic        wr_err;
    logic        w_fire;
    logic        w_final;

    assign w_fire  = wvalid && wready;
    assign w_final = (wr_cnt == wr_len);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state <= W_IDLE;
            wr_id    <= 4'd0;
            wr_addr  <= 32'd0;
            wr_len   <= 8'd0;
            wr_cnt   <= 8'd0;
            wr_size  <= 3'd0;
            wr_burst <= 2'd0;
            wr_err   <= 1'b0;
        end else begin
            case (wr_state)
                W_IDLE: begin
                    if (awvalid) begin
                        wr_id    <= awid;
                        wr_addr  <= awaddr;
                        wr_len   <= awlen;
                        wr_size  <= awsize;
                        wr_burst <= awburst;
                        wr_cnt   <= 8'd0;
                        wr_err   <= (awsize > 3'd2);
                        wr_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (wvalid) begin
                        wr_addr <= next_addr(wr_addr, wr_size, wr_burst);
                        wr_cnt  <= wr_cnt + 8'd1;
                        // The beat count, not wlast, ends the burst; a misplaced wlast only flags it.
                        if (wlast != w_final) begin
                            wr_err <= 1'b1;
                        end
                        if (w_final) begin
                            wr_state <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        wr_state <= W_IDLE;
                    end
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    assign awready = (wr_state == W_IDLE) && !rst;
    assign wready  = (wr_state == W_DATA);
    assign bvalid  = (wr_state == W_RESP);
    assign bid     = wr_id;
    assign bresp   = (bvalid && wr_err) ? RESP_SLVERR : RESP_OKAY;

    axi_sram_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .re    (ar_fire || r_fire),
        .raddr (ar_fire ? araddr[ADDR_W+1:2] : rd_addr_nxt[ADDR_W+1:2]),
        .rdata (mem_rdata),
        .we    (w_fire),
        .waddr (wr_addr[ADDR_W+1:2]),
        .wdata (wdata),
        .wstrb (wstrb)
    );

endmodule
